dcp_pkt_fifo: RTL and testbench
===============================

Name: dcp_pkt_fifo

Overview:
Packet-aware successor to the Decoupled FIFO for the switch datapath. Buffers Decoupled beats framed by a Last flag and supports two modes, selected by parameter:
- Cut-through: behaves as a plain FIFO.
- Store-and-forward: a packet becomes visible at the output only after its last beat is accepted; errored or oversize packets are dropped by rolling back the write pointer.

Sits between MAC RX and the switch ingress/egress queues.

Parameters:
DATA_WIDTH, 32, payload width in bits
DEPTH, 16, beat storage; power of two, >= 2
STORE_FWD, 1, 1 = store-and-forward, 0 = cut-through
ADDR_W, $clog2(DEPTH), derived; do not override

Ports:
iClk  input  1  clock
iRst  input  1  synchronous active-high reset
iFlush  input  1  synchronous clear of all contents, including any in-flight packet
iInVld  input  1  input beat valid
oInRdy  output  1  input ready
iInPld  input  DATA_WIDTH  input payload
iInLast  input  1  last beat of packet
iInErr  input  1  packet error; sampled only on the last beat
oOutVld  output  1  output beat valid
iOutRdy  input  1  output ready
oOutPld  output  DATA_WIDTH  output payload
oOutLast  output  1  last beat of packet
oOutErr  output  1  error flag on the last beat (cut-through only; always 0 in store-and-forward)
oUsage  output  ADDR_W+1  beats held, committed plus uncommitted

Behaviour:
- Interface: one clock, iClk. Reset is synchronous and active-high, on iRst.
- Reset and flush:
  - On iRst, or on iFlush when iRst is low, all pointers clear and the drop state clears.
  - Outputs the cycle after reset or flush: oOutVld=0, oInRdy=1, oUsage=0, oOutLast=0, oOutErr=0, oOutPld=0.
  - iRst asserted mid-packet discards the partial packet. No drop is counted.
- Storage:
  - Flop array holding {Pld, Last, Err}.
  - Pointers are ADDR_W+1 bits wide: wr, commit, rd. The MSB is the wrap bit.
  - Full is when wr-rd == DEPTH. Empty is when commit == rd.
  - All pointer arithmetic is modulo 2^(ADDR_W+1).
- Accept: a beat is accepted when iInVld && oInRdy. oInRdy = ~full, except in the DROP state (see below).
- Cut-through mode:
  - commit tracks wr every cycle.
  - A beat accepted in cycle N drives oOutVld in cycle N+1.
  - iInErr is stored and presented on oOutErr with the last beat.
- Store-and-forward write FSM, states IDLE / PKT / DROP:
  - IDLE to PKT on an accepted non-last beat.
  - An accepted last beat with Err=0 sets commit = wr+1. The packet becomes visible at oOutVld in the next cycle.
  - An accepted last beat with Err=1 restores wr to commit. Nothing becomes visible, and oUsage drops back.
  - Oversize: full while in PKT with wr-commit == DEPTH. Go to DROP and roll wr back to commit. In DROP, oInRdy=1 and beats are discarded until the last beat is accepted, then return to IDLE.
  - Full while in PKT with earlier packets still stored is back-pressure (oInRdy=0), not a drop.
- Read side:
  - oOutVld = ~empty. Output is registered and taken from the array (show-ahead).
  - Pop when oOutVld && iOutRdy; rd increments.
  - Outputs hold stable while oOutVld && ~iOutRdy.
- Simultaneous push and pop while full: the pop frees a slot next cycle. oInRdy is not combinationally dependent on iOutRdy.
- Simultaneous commit and pop: oUsage = wr - rd after both updates.
- Throughput: one beat per cycle on each side.

Optional Feature:
DCP_FIFO_STATS_EN
- When defined, adds two output ports, both cleared by iRst only (not by iFlush):
  - oPktCnt (16 bits): committed packets.
  - oDropCnt (16 bits): error drops plus oversize drops.
  - Both saturate at 16'hFFFF.
- When undefined, the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package dcp_fifo_pkg holds:
  - typedef enum wr_state_e {IDLE, PKT, DROP};
  - localparam CNT_W = 16;
  - typedef struct beat_t {Pld, Last, Err}, parametrised via a width function.
- Sub-module dcp_fifo_mem: DEPTH x (DATA_WIDTH+2) flop array with one write port and one registered read port.
- The FSM and pointers live in the top module.

Test Plan:
- Store-and-forward, DEPTH=16: push a 4-beat packet 0xA0..0xA3 with iOutRdy=1. oOutVld stays 0 until the cycle after the last beat, then emits 0xA0..0xA3 with oOutLast on 0xA3; oUsage returns to 0.
- Store-and-forward: 3-beat packet with iInErr=1 on the last beat. No output, oUsage is 0 the cycle after, oDropCnt=1.
- Store-and-forward: 20-beat packet into an empty FIFO with DEPTH=16. DROP is entered at beat 16 and all 20 beats are accepted. No output, oDropCnt=1, and a following 2-beat packet emerges intact.
- Cut-through: stream 40 beats with iOutRdy toggling 1,0. Output order is exact, there are no losses, oUsage never exceeds 16, and the first beat is valid at N+1.
- Store-and-forward: fill with four 4-beat packets (full) while iOutRdy=0, then push and pop in the same cycle. Exactly one beat leaves, oInRdy rises the next cycle, and data order is preserved.
- Mid-packet: assert iFlush after 2 beats of a 5-beat packet. All outputs take reset values the next cycle, oDropCnt is unchanged, and the next packet passes cleanly.

Source files
------------

// File: rtl/dcp_fifo_pkg.sv
// Shared types and constants for the packet-aware Decoupled FIFO (dcp_pkt_fifo).
package dcp_fifo_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } wr_state_e;

  // Stored beat is {pld, last, err}; the struct itself is declared where DATA_WIDTH is known.
  function automatic int beat_w(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/dcp_fifo_mem.sv
// Flop-array beat store: one write port, one registered read port with write-through bypass.
module dcp_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 34,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // A beat written this cycle may already be the next head, so forward it straight to the output.
  always_comb begin
    rdata_d = rdata_q;
    if (clr) begin
      rdata_d = '0;
    end else if (re) begin
      rdata_d = (we && (waddr == raddr)) ? wdata : mem_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dcp_pkt_fifo.sv
// Packet-aware FIFO: cut-through or store-and-forward with error/oversize drop by write-pointer rollback.
// Optional packet/drop statistics counters are enabled by defining DCP_FIFO_STATS_EN.
module dcp_pkt_fifo
  import dcp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int STORE_FWD  = 1,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iFlush,
  input  logic                  iInVld,
  output logic                  oInRdy,
  input  logic [DATA_WIDTH-1:0] iInPld,
  input  logic                  iInLast,
  input  logic                  iInErr,
  output logic                  oOutVld,
  input  logic                  iOutRdy,
  output logic [DATA_WIDTH-1:0] oOutPld,
  output logic                  oOutLast,
  output logic                  oOutErr,
  output logic [ADDR_W:0]       oUsage,
  output logic [1:0]            oDbgWrState
`ifdef DCP_FIFO_STATS_EN
  ,
  output logic [CNT_W-1:0]      oPktCnt,
  output logic [CNT_W-1:0]      oDropCnt
`endif
);

  // Handshake: a beat moves on either side only in a cycle where valid and ready are both high;
  // ready never depends combinationally on valid, and the output side holds steady while stalled.

  localparam int              BW      = beat_w(DATA_WIDTH);
  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pld;
    logic                  last;
    logic                  err;
  } beat_t;

  logic [ADDR_W:0] wr_q, wr_d, cmt_q, cmt_d, rd_q, rd_d;
  wr_state_e       state_q, state_d;
  logic [ADDR_W:0] used, pend;
  logic            full, in_rdy, acc, pop, clr, we, re;
  logic            pkt_done, drop_evt;
  beat_t           wbeat, rbeat;
  logic [BW-1:0]   rdata;

  assign clr    = iRst || iFlush;
  assign used   = wr_q - rd_q;
  assign pend   = wr_q - cmt_q;
  assign full   = (used == DEPTH_P);
  assign in_rdy = (state_q == DROP) || !full;
  assign acc    = iInVld && in_rdy;
  assign pop    = (cmt_q != rd_q) && iOutRdy;

  always_comb begin
    wr_d     = wr_q;
    cmt_d    = cmt_q;
    rd_d     = rd_q;
    state_d  = state_q;
    we       = 1'b0;
    pkt_done = 1'b0;
    drop_evt = 1'b0;
    if (pop) rd_d = rd_q + 1'b1;
    if (STORE_FWD == 0) begin
      if (acc) begin
        we       = 1'b1;
        wr_d     = wr_q + 1'b1;
        pkt_done = iInLast;
      end
      cmt_d = wr_d;
    end else begin
      case (state_q)
        DROP: begin
          if (acc && iInLast) state_d = IDLE;
        end
        default: begin
          // A packet filling the whole store on its own can never commit: abandon it.
          if ((state_q == PKT) && full && (pend == DEPTH_P)) begin
            state_d  = DROP;
            wr_d     = cmt_q;
            drop_evt = 1'b1;
          end else if (acc) begin
            we   = 1'b1;
            wr_d = wr_q + 1'b1;
            if (!iInLast) begin
              state_d = PKT;
            end else begin
              state_d = IDLE;
              if (iInErr) begin
                wr_d     = cmt_q;
                drop_evt = 1'b1;
              end else begin
                cmt_d    = wr_q + 1'b1;
                pkt_done = 1'b1;
              end
            end
          end
        end
      endcase
    end
    if (clr) begin
      wr_d     = '0;
      cmt_d    = '0;
      rd_d     = '0;
      state_d  = IDLE;
      we       = 1'b0;
      pkt_done = 1'b0;
      drop_evt = 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    wr_q    <= wr_d;
    cmt_q   <= cmt_d;
    rd_q    <= rd_d;
    state_q <= state_d;
  end

  assign re    = (cmt_d != rd_d);
  assign wbeat = '{pld: iInPld, last: iInLast, err: iInErr};

  dcp_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (BW),
    .AW    (ADDR_W)
  ) u_mem (
    .clk   (iClk),
    .clr   (clr),
    .we    (we),
    .waddr (wr_q[ADDR_W-1:0]),
    .wdata (wbeat),
    .re    (re),
    .raddr (rd_d[ADDR_W-1:0]),
    .rdata (rdata)
  );

  assign rbeat       = beat_t'(rdata);
  assign oInRdy      = in_rdy;
  assign oOutVld     = (cmt_q != rd_q);
  assign oOutPld     = rbeat.pld;
  assign oOutLast    = rbeat.last;
  assign oOutErr     = (STORE_FWD == 0) ? rbeat.err : 1'b0;
  assign oUsage      = used;
  assign oDbgWrState = state_q;

`ifdef DCP_FIFO_STATS_EN
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;

  // Statistics survive iFlush; only iRst clears them.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (pkt_done && (pkt_cnt_q != '1)) pkt_cnt_d = pkt_cnt_q + 1'b1;
    if (drop_evt && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
    if (iRst) begin
      pkt_cnt_d  = '0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge iClk) begin
    pkt_cnt_q  <= pkt_cnt_d;
    drop_cnt_q <= drop_cnt_d;
  end

  assign oPktCnt  = pkt_cnt_q;
  assign oDropCnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_dcp_pkt_fifo.sv
// Scoreboard bench for dcp_pkt_fifo: one store-and-forward and one cut-through instance.
module tb_dcp_pkt_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  // store-and-forward instance
  logic        sf_in_vld = 1'b0, sf_in_last = 1'b0, sf_in_err = 1'b0, sf_out_rdy = 1'b0;
  logic [31:0] sf_in_pld = '0;
  logic        sf_in_rdy, sf_out_vld, sf_out_last, sf_out_err;
  logic [31:0] sf_out_pld;
  logic [4:0]  sf_usage;
  logic [1:0]  sf_state;
  logic [15:0] sf_pkt_cnt, sf_drop_cnt;

  // cut-through instance
  logic        ct_in_vld = 1'b0, ct_in_last = 1'b0, ct_in_err = 1'b0, ct_out_rdy = 1'b0;
  logic [31:0] ct_in_pld = '0;
  logic        ct_in_rdy, ct_out_vld, ct_out_last, ct_out_err;
  logic [31:0] ct_out_pld;
  logic [4:0]  ct_usage;
  logic [1:0]  ct_state;
  logic [15:0] ct_pkt_cnt, ct_drop_cnt;
  logic        ct_active = 1'b0;

  logic [32:0] sf_q[$];
  logic [33:0] ct_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  dcp_pkt_fifo #(.DATA_WIDTH(32), .DEPTH(16), .STORE_FWD(1)) dut_sf (
    .iClk(clk), .iRst(rst), .iFlush(flush),
    .iInVld(sf_in_vld), .oInRdy(sf_in_rdy), .iInPld(sf_in_pld), .iInLast(sf_in_last), .iInErr(sf_in_err),
    .oOutVld(sf_out_vld), .iOutRdy(sf_out_rdy), .oOutPld(sf_out_pld), .oOutLast(sf_out_last),
    .oOutErr(sf_out_err), .oUsage(sf_usage), .oDbgWrState(sf_state)
`ifdef DCP_FIFO_STATS_EN
    , .oPktCnt(sf_pkt_cnt), .oDropCnt(sf_drop_cnt)
`endif
  );

  dcp_pkt_fifo #(.DATA_WIDTH(32), .DEPTH(16), .STORE_FWD(0)) dut_ct (
    .iClk(clk), .iRst(rst), .iFlush(1'b0),
    .iInVld(ct_in_vld), .oInRdy(ct_in_rdy), .iInPld(ct_in_pld), .iInLast(ct_in_last), .iInErr(ct_in_err),
    .oOutVld(ct_out_vld), .iOutRdy(ct_out_rdy), .oOutPld(ct_out_pld), .oOutLast(ct_out_last),
    .oOutErr(ct_out_err), .oUsage(ct_usage), .oDbgWrState(ct_state)
`ifdef DCP_FIFO_STATS_EN
    , .oPktCnt(ct_pkt_cnt), .oDropCnt(ct_drop_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic flag(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout, expected handshake", nm);
  endtask

  // monitors: pop and compare whenever a beat leaves either DUT
  always @(negedge clk) begin
    if (!rst && sf_out_vld && sf_out_rdy) begin
      if (sf_q.size() == 0) chk("sf_unexpected_beat", 64'({sf_out_last, sf_out_pld}), 64'h1_dead_beef);
      else chk("sf_out_beat", 64'({sf_out_last, sf_out_pld}), 64'(sf_q.pop_front()));
    end
    if (!rst && ct_out_vld && ct_out_rdy) begin
      if (ct_q.size() == 0) chk("ct_unexpected_beat", 64'({ct_out_err, ct_out_last, ct_out_pld}), 64'h3_dead_beef);
      else chk("ct_out_beat", 64'({ct_out_err, ct_out_last, ct_out_pld}), 64'(ct_q.pop_front()));
    end
    if (ct_active) chk("ct_usage_le_16", 64'(ct_usage <= 5'd16), 64'd1);
  end

  // driver tasks: called at posedge+1, return at posedge+1 after the beat is accepted
  task automatic sf_beat(input logic [31:0] pld, input logic last, input logic err, input logic no_vld);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    sf_in_vld = 1'b1; sf_in_pld = pld; sf_in_last = last; sf_in_err = err;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = sf_in_rdy;
      if (no_vld) chk("sf_no_early_vld", 64'(sf_out_vld), 64'd0);
      @(posedge clk); #1;
      n++;
    end
    sf_in_vld = 1'b0; sf_in_last = 1'b0; sf_in_err = 1'b0;
    if (!acc) flag("sf_accept_timeout");
  endtask

  task automatic ct_beat(input logic [31:0] pld, input logic last, input logic err);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    ct_in_vld = 1'b1; ct_in_pld = pld; ct_in_last = last; ct_in_err = err;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ct_in_rdy;
      @(posedge clk); #1;
      n++;
    end
    ct_in_vld = 1'b0; ct_in_last = 1'b0; ct_in_err = 1'b0;
    if (!acc) flag("ct_accept_timeout");
  endtask

  task automatic sf_drain();
    int n;
    n = 0;
    sf_out_rdy = 1'b1;
    @(negedge clk);
    while ((sf_q.size() != 0 || sf_out_vld) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) flag("sf_drain_timeout");
    chk("sf_drain_usage", 64'(sf_usage), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_sf_vld",  64'(sf_out_vld), 64'd0);
    chk("rst_sf_rdy",  64'(sf_in_rdy), 64'd1);
    chk("rst_sf_use",  64'(sf_usage), 64'd0);
    chk("rst_sf_out",  64'({sf_out_last, sf_out_err, sf_out_pld}), 64'd0);
    chk("rst_ct_vld",  64'(ct_out_vld), 64'd0);
    chk("rst_ct_rdy",  64'(ct_in_rdy), 64'd1);
    @(posedge clk); #1;

    // 4-beat good packet: nothing visible until the last beat is in
    sf_out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) sf_q.push_back({(i == 3), 32'hA0 + 32'(i)});
    for (int i = 0; i < 4; i++) sf_beat(32'hA0 + 32'(i), (i == 3), 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_vld_after_last", 64'(sf_out_vld), 64'd1);
    sf_drain();
`ifdef DCP_FIFO_STATS_EN
    chk("t1_pkt_cnt", 64'(sf_pkt_cnt), 64'd1);
`endif

    // 3-beat packet with error on the last beat: rolled back
    for (int i = 0; i < 3; i++) sf_beat(32'hB0 + 32'(i), (i == 2), (i == 2), 1'b1);
    @(negedge clk);
    chk("t2_usage_after_err", 64'(sf_usage), 64'd0);
    repeat (3) @(negedge clk);
    chk("t2_no_output", 64'(sf_out_vld), 64'd0);
`ifdef DCP_FIFO_STATS_EN
    chk("t2_drop_cnt", 64'(sf_drop_cnt), 64'd1);
`endif
    @(posedge clk); #1;

    // 20-beat oversize packet, then a 2-beat packet
    for (int i = 0; i < 20; i++) begin
      sf_beat(32'hC0 + 32'(i), (i == 19), 1'b0, 1'b1);
      if (i == 15) begin
        @(negedge clk);
        chk("t3_usage_full", 64'(sf_usage), 64'd16);
        @(posedge clk); #1;
      end
      if (i == 16) begin
        @(negedge clk);
        chk("t3_state_drop", 64'(sf_state), 64'd2);
        chk("t3_usage_rolled_back", 64'(sf_usage), 64'd0);
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    chk("t3_state_idle", 64'(sf_state), 64'd0);
    chk("t3_no_output", 64'(sf_out_vld), 64'd0);
    @(posedge clk); #1;
`ifdef DCP_FIFO_STATS_EN
    chk("t3_drop_cnt", 64'(sf_drop_cnt), 64'd2);
`endif
    sf_q.push_back({1'b0, 32'hD0});
    sf_q.push_back({1'b1, 32'hD1});
    sf_beat(32'hD0, 1'b0, 1'b0, 1'b0);
    sf_beat(32'hD1, 1'b1, 1'b0, 1'b0);
    sf_drain();

    // fill with four 4-beat packets, then push and pop in the same cycle
    sf_out_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sf_q.push_back({(i % 4 == 3), 32'hE0 + 32'(i)});
      sf_beat(32'hE0 + 32'(i), (i % 4 == 3), 1'b0, 1'b0);
    end
    @(negedge clk);
    chk("t4_full_rdy", 64'(sf_in_rdy), 64'd0);
    chk("t4_full_usage", 64'(sf_usage), 64'd16);
    @(posedge clk); #1;
    sf_q.push_back({1'b1, 32'hF0});
    sf_in_vld = 1'b1; sf_in_pld = 32'hF0; sf_in_last = 1'b1; sf_out_rdy = 1'b1;
    @(negedge clk);
    chk("t4_rdy_while_popping", 64'(sf_in_rdy), 64'd0);
    @(posedge clk); #1;
    sf_out_rdy = 1'b0;
    @(negedge clk);
    chk("t4_rdy_rises", 64'(sf_in_rdy), 64'd1);
    chk("t4_one_left", 64'(sf_usage), 64'd15);
    @(posedge clk); #1;
    sf_in_vld = 1'b0; sf_in_last = 1'b0;
    @(negedge clk);
    chk("t4_refilled", 64'(sf_usage), 64'd16);
    @(posedge clk); #1;
    sf_drain();

    // flush mid-packet
    sf_beat(32'h90, 1'b0, 1'b0, 1'b1);
    sf_beat(32'h91, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("t5_flush_vld", 64'(sf_out_vld), 64'd0);
    chk("t5_flush_rdy", 64'(sf_in_rdy), 64'd1);
    chk("t5_flush_usage", 64'(sf_usage), 64'd0);
    chk("t5_flush_out", 64'({sf_out_last, sf_out_err, sf_out_pld}), 64'd0);
`ifdef DCP_FIFO_STATS_EN
    chk("t5_drop_cnt_kept", 64'(sf_drop_cnt), 64'd2);
`endif
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      sf_q.push_back({(i == 2), 32'h50 + 32'(i)});
      sf_beat(32'h50 + 32'(i), (i == 2), 1'b0, 1'b0);
    end
    sf_drain();

    // cut-through stream with toggling output ready
    ct_active = 1'b1;
    ct_out_rdy = 1'b1;
    for (int i = 0; i < 40; i++) ct_q.push_back({(i == 15), (i % 8 == 7), 32'h100 + 32'(i)});
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          ct_beat(32'h100 + 32'(i), (i % 8 == 7), (i == 15));
          if (i == 0) begin
            @(negedge clk);
            chk("ct_first_vld_n_plus_1", 64'(ct_out_vld), 64'd1);
            @(posedge clk); #1;
          end
        end
      end
      begin
        int n;
        n = 0;
        while ((ct_q.size() != 0 || ct_in_vld) && n < 1000) begin
          @(posedge clk); #1;
          ct_out_rdy = ~ct_out_rdy;
          n++;
        end
        if (n >= 1000) flag("ct_drain_timeout");
      end
    join
    ct_out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("ct_drained_usage", 64'(ct_usage), 64'd0);
    chk("ct_all_beats_out", 64'(ct_q.size()), 64'd0);
    ct_active = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
